vec_fp16_alu: RTL and testbench

Lane-serial, parametrised FP16 (1/5/10, bias 15) vector ALU that succeeds the single-opcode 256-bit datapath. It supports VADD, SMUL, VDOT and NOP across a configurable lane count. A single shared adder and a single shared multiplier are time-multiplexed over the lanes under a small FSM. Operands enter and results leave over valid/ready handshakes, so the block sits between the decode/register-read stage and writeback.

---
 rtl/vec_fp16_alu.sv | 173 +++++++++++++++++
 tb/tb_vec_fp16_alu.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_fp16_alu.sv
// Lane-serial FP16 vector ALU: VADD, VDOT, SMUL, NOP over LANES lanes.
// One shared adder and one shared multiplier are stepped across the lanes.
module vec_fp16_alu #(
  parameter int LANES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           opcode,
  input  logic [16*LANES-1:0]  op_1,
  input  logic [16*LANES-1:0]  op_2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*LANES-1:0]  result,
  output logic                 out_err
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [15:0] fp_add(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [15:0] g, s, r;
    logic [4:0]  d;
    logic [10:0] al, sh;
    logic [11:0] m;
    logic [3:0]  lz;
    g = (a[14:0] >= b[14:0]) ? a : b;
    s = (a[14:0] >= b[14:0]) ? b : a;
    d = g[14:10] - s[14:10];
    al = {1'b1, s[9:0]} >> d;
    if (a[15] == b[15])
      m = {2'b01, g[9:0]} + {1'b0, al};
    else
      m = {2'b01, g[9:0]} - {1'b0, al};
    lz = 4'd0;
    for (int i = 0; i <= 10; i++)
      if (m[i]) lz = 4'(10 - i);
    sh = m[10:0] << lz;
    if (a[14:10] == 5'h1f)
      r = {a[15], 5'h1f, 10'h0};
    else if (b[14:10] == 5'h1f)
      r = {b[15], 5'h1f, 10'h0};
    else if (b[14:10] == 5'h0)
      r = (a[14:10] == 5'h0) ? 16'h0 : a;
    else if (a[14:10] == 5'h0)
      r = b;
    else if (d > 5'd11)
      r = g;
    else if (m[11])
      r = (g[14:10] == 5'd30) ? {g[15], 5'h1f, 10'h0}
                              : {g[15], g[14:10] + 5'd1, m[10:1]};
    else if (m == 12'h0)
      r = 16'h0;
    else if ({1'b0, g[14:10]} <= {2'b0, lz})
      r = 16'h0;
    else
      r = {g[15], g[14:10] - {1'b0, lz}, sh[9:0]};
    return r;
  endfunction

  function automatic logic [15:0] fp_mul(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [21:0] p;
    logic [6:0]  t;
    logic [9:0]  f;
    logic [15:0] r;
    logic        sg;
    sg = a[15] ^ b[15];
    p = {11'b0, 1'b1, a[9:0]} * {11'b0, 1'b1, b[9:0]};
    t = {2'b0, a[14:10]} + {2'b0, b[14:10]} + {6'b0, p[21]};
    f = p[21] ? p[20:11] : p[19:10];
    if (a[14:10] == 5'h0 || b[14:10] == 5'h0)
      r = 16'h0;
    else if (a[14:10] == 5'h1f || b[14:10] == 5'h1f)
      r = {sg, 5'h1f, 10'h0};
    else if (t < 7'd16)
      r = 16'h0;
    else if (t > 7'd45)
      r = {sg, 5'h1f, 10'h0};
    else
      r = {sg, 5'(t - 7'd15), f};
    return r;
  endfunction

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [3:0]           op_q;
  logic [16*LANES-1:0]  a_q, b_q, work;
  logic [16*LANES-1:0]  nwork, fin;
  logic [15:0]          acc, la, lb, prod, sum, lane;
  logic                 is_vadd, is_vdot, is_smul, is_nop, illegal;

  assign is_vadd = (op_q == 4'b0000);
  assign is_vdot = (op_q == 4'b0001);
  assign is_smul = (op_q == 4'b0010);
  assign is_nop  = (op_q == 4'b1111);
  assign illegal = ~(is_vadd | is_vdot | is_smul | is_nop);

  always_comb begin
    la = a_q[{cnt, 4'b0} +: 16];
    lb = b_q[{cnt, 4'b0} +: 16];
    prod = fp_mul(is_smul ? a_q[15:0] : la, lb);
    sum = fp_add(is_vdot ? acc : la, is_vdot ? prod : lb);
    lane = 16'h0;
    unique case (1'b1)
      is_vadd: lane = sum;
      is_smul: lane = prod;
      is_nop:  lane = la;
      default: lane = 16'h0;
    endcase
    nwork = work;
    nwork[{cnt, 4'b0} +: 16] = lane;
    fin = nwork;
    // VDOT leaves lanes 1.. at zero; lane 0 is the final sum
    if (is_vdot) fin[15:0] = sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= 4'h0;
      a_q       <= '0;
      b_q       <= '0;
      work      <= '0;
      acc       <= 16'h0;
      result    <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q     <= opcode;
          a_q      <= op_1;
          b_q      <= op_2;
          cnt      <= '0;
          acc      <= 16'h0;
          work     <= '0;
          in_ready <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          work <= nwork;
          if (is_vdot) acc <= sum;
          if (cnt == LAST) begin
            result    <= fin;
            out_err   <= illegal;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_fp16_alu.sv
// Self-checking bench for vec_fp16_alu: directed cases plus random ops
// checked against an integer-arithmetic FP16 model.
module tb_vec_fp16_alu;

  localparam int L = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     opcode;
  logic [16*L-1:0] op_1, op_2;
  logic           out_valid;
  logic           out_ready;
  logic [16*L-1:0] result;
  logic           out_err;

  int checks = 0;
  int errors = 0;

  vec_fp16_alu #(.LANES(L)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .op_1(op_1), .op_2(op_2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] inf_of(input logic s);
    return {s, 5'h1f, 10'h0};
  endfunction

  function automatic logic [15:0] m_add(input logic [15:0] a,
                                        input logic [15:0] b);
    int ea, eb, eg, es, fg, fs, d, m, e;
    logic sg;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if (ea == 31) return inf_of(a[15]);
    if (eb == 31) return inf_of(b[15]);
    if (ea == 0 && eb == 0) return 16'h0;
    if (ea == 0) return b;
    if (eb == 0) return a;
    if (a[14:0] >= b[14:0]) begin
      sg = a[15]; eg = ea; fg = int'(a[9:0]); es = eb; fs = int'(b[9:0]);
    end else begin
      sg = b[15]; eg = eb; fg = int'(b[9:0]); es = ea; fs = int'(a[9:0]);
    end
    d = eg - es;
    if (d > 11) return (a[14:0] >= b[14:0]) ? a : b;
    if (a[15] == b[15]) m = (1024 + fg) + ((1024 + fs) >> d);
    else                m = (1024 + fg) - ((1024 + fs) >> d);
    if (m == 0) return 16'h0;
    e = eg;
    while (m >= 2048) begin m = m >> 1; e++; end
    while (m < 1024) begin m = m << 1; e--; end
    if (e < 1) return 16'h0;
    if (e > 30) return inf_of(sg);
    return {sg, 5'(e), 10'(m)};
  endfunction

  function automatic logic [15:0] m_mul(input logic [15:0] a,
                                        input logic [15:0] b);
    int ea, eb, e;
    longint p;
    logic sg;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    sg = a[15] ^ b[15];
    if (ea == 0 || eb == 0) return 16'h0;
    if (ea == 31 || eb == 31) return inf_of(sg);
    p = longint'(1024 + int'(a[9:0])) * longint'(1024 + int'(b[9:0]));
    e = ea + eb - 15;
    while (p >= 2048 * 1024) begin p = p >> 1; e++; end
    if (e < 1) return 16'h0;
    if (e > 30) return inf_of(sg);
    return {sg, 5'(e), 10'(p >> 10)};
  endfunction

  task automatic model(input logic [3:0] op,
                       input logic [16*L-1:0] a, input logic [16*L-1:0] b,
                       output logic [16*L-1:0] r, output logic err);
    logic [15:0] acc;
    r = '0;
    err = 1'b0;
    acc = 16'h0;
    for (int i = 0; i < L; i++) begin
      case (op)
        4'b0000: r[16*i +: 16] = m_add(a[16*i +: 16], b[16*i +: 16]);
        4'b0010: r[16*i +: 16] = m_mul(a[15:0], b[16*i +: 16]);
        4'b0001: acc = m_add(acc, m_mul(a[16*i +: 16], b[16*i +: 16]));
        4'b1111: r[16*i +: 16] = a[16*i +: 16];
        default: err = 1'b1;
      endcase
    end
    if (op == 4'b0001) r[15:0] = acc;
  endtask

  function automatic logic [16*L-1:0] splat(input logic [15:0] v);
    logic [16*L-1:0] r;
    for (int i = 0; i < L; i++) r[16*i +: 16] = v;
    return r;
  endfunction

  function automatic logic [15:0] rand_fp();
    int k;
    logic [4:0] e;
    k = int'($urandom_range(0, 9));
    if (k == 0) e = 5'h0;
    else if (k == 1) e = 5'h1f;
    else if (k < 6) e = 5'($urandom_range(12, 18));
    else e = 5'($urandom_range(1, 30));
    return {1'($urandom), e, 10'($urandom)};
  endfunction

  task automatic run_op(input logic [3:0] op,
                        input logic [16*L-1:0] a, input logic [16*L-1:0] b,
                        output logic [16*L-1:0] res, output logic err,
                        output int lat);
    int n;
    opcode = op;
    op_1 = a;
    op_2 = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    res = result;
    err = out_err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    opcode = 4'h0;
    op_1 = '0;
    op_2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0",
               in_ready, out_valid);
    end
    checks++;
    if (result !== '0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: result=%h err=%b want 0/0", result, out_err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_vadd_ones();
    logic [16*L-1:0] r;
    logic e;
    int lat;
    run_op(4'b0000, splat(16'h3C00), splat(16'h3C00), r, e, lat);
    checks++;
    if (r !== splat(16'h4000) || e !== 1'b0) begin
      errors++;
      $display("FAIL vadd_ones: got %h err=%b want %h err=0",
               r, e, splat(16'h4000));
    end
    checks++;
    if (lat !== L) begin
      errors++;
      $display("FAIL vadd_latency: got %0d want %0d", lat, L);
    end
  endtask

  task automatic test_vadd_edges();
    logic [16*L-1:0] a, b, r, x;
    logic e;
    int lat;
    a = splat(16'h3C00);
    b = splat(16'h3C00);
    x = splat(16'h4000);
    a[15:0]  = 16'h7BFF; b[15:0]  = 16'h7BFF; x[15:0]  = 16'h7C00;
    a[31:16] = 16'h3C00; b[31:16] = 16'hBC00; x[31:16] = 16'h0000;
    a[47:32] = 16'h0001; b[47:32] = 16'h3C00; x[47:32] = 16'h3C00;
    a[63:48] = 16'h7C00; b[63:48] = 16'hFC00; x[63:48] = 16'h7C00;
    run_op(4'b0000, a, b, r, e, lat);
    checks++;
    if (r !== x || e !== 1'b0) begin
      errors++;
      $display("FAIL vadd_edges: got %h err=%b want %h err=0", r, e, x);
    end
  endtask

  task automatic test_smul();
    logic [16*L-1:0] a, b, r;
    logic e;
    int lat;
    a = splat(16'h4400);
    a[15:0] = 16'h4000;
    run_op(4'b0010, a, splat(16'h3E00), r, e, lat);
    checks++;
    if (r !== splat(16'h4200) || e !== 1'b0) begin
      errors++;
      $display("FAIL smul_basic: got %h err=%b want %h",
               r, e, splat(16'h4200));
    end
    a[15:0] = 16'h0000;
    b = splat(16'h3E00);
    b[63:48] = 16'h7C00;
    run_op(4'b0010, a, b, r, e, lat);
    checks++;
    if (r !== '0 || e !== 1'b0) begin
      errors++;
      $display("FAIL smul_zero: got %h err=%b want 0", r, e);
    end
  endtask

  task automatic test_vdot();
    logic [16*L-1:0] r, x;
    logic e;
    int lat;
    x = '0;
    x[15:0] = 16'h5000;
    run_op(4'b0001, splat(16'h3C00), splat(16'h4000), r, e, lat);
    checks++;
    if (r !== x || e !== 1'b0) begin
      errors++;
      $display("FAIL vdot_32: got %h err=%b want %h", r, e, x);
    end
    checks++;
    if (lat !== L) begin
      errors++;
      $display("FAIL vdot_latency: got %0d want %0d", lat, L);
    end
  endtask

  task automatic test_backpressure();
    logic [16*L-1:0] a, b, x, r0;
    logic xe;
    int n, bad, seen;
    for (int i = 0; i < L; i++) begin
      a[16*i +: 16] = rand_fp();
      b[16*i +: 16] = rand_fp();
    end
    model(4'b0000, a, b, x, xe);
    opcode = 4'b0000; op_1 = a; op_2 = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    r0 = result;
    checks++;
    if (r0 !== x || n !== L) begin
      errors++;
      $display("FAIL bp_result: got %h lat=%0d want %h lat=%0d",
               r0, n, x, L);
    end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        opcode = 4'b1111;
        op_1 = splat(16'h1234);
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (result !== r0 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d bad cycles want 0", bad);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1",
               out_valid, in_ready);
    end
    seen = 0;
    repeat (L + 4) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL bp_single: extra out_valid cycles=%0d want 0", seen);
    end
  endtask

  task automatic test_reset_midrun_illegal();
    logic [16*L-1:0] r;
    logic e;
    int lat, seen;
    opcode = 4'b0001;
    op_1 = splat(16'h3C00);
    op_2 = splat(16'h4000);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
      errors++;
      $display("FAIL midrun_reset: ov=%b ir=%b res=%h want 0/1/0",
               out_valid, in_ready, result);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (L + 4) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrun_abandon: out_valid cycles=%0d want 0", seen);
    end
    run_op(4'b0011, splat(16'h3C00), splat(16'h3C00), r, e, lat);
    checks++;
    if (r !== '0 || e !== 1'b1) begin
      errors++;
      $display("FAIL illegal_op: got %h err=%b want 0 err=1", r, e);
    end
    checks++;
    if (lat !== L) begin
      errors++;
      $display("FAIL illegal_latency: got %0d want %0d", lat, L);
    end
  endtask

  task automatic test_random();
    logic [16*L-1:0] a, b, r, x;
    logic e, xe;
    logic [3:0] op;
    int lat, k;
    for (int t = 0; t < 40; t++) begin
      k = int'($urandom_range(0, 4));
      case (k)
        0: op = 4'b0000;
        1: op = 4'b0001;
        2: op = 4'b0010;
        3: op = 4'b1111;
        default: op = 4'($urandom_range(3, 14));
      endcase
      for (int i = 0; i < L; i++) begin
        a[16*i +: 16] = rand_fp();
        b[16*i +: 16] = rand_fp();
      end
      model(op, a, b, x, xe);
      run_op(op, a, b, r, e, lat);
      checks++;
      if (r !== x || e !== xe) begin
        errors++;
        $display("FAIL rand_%0d op=%h: got %h err=%b want %h err=%b",
                 t, op, r, e, x, xe);
      end
      checks++;
      if (lat !== L) begin
        errors++;
        $display("FAIL rand_lat_%0d: got %0d want %0d", t, lat, L);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vadd_ones();
    test_vadd_edges();
    test_smul();
    test_vdot();
    test_backpressure();
    test_reset_midrun_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
